// File: rtl/posit_mul_core_seq.sv
// Iterative radix-2 shift-add posit significand multiplier.
// Produces sign/scale/fraction/guard/sticky/nzn fields for the downstream posit encoder.
module posit_mul_core_seq #(
    parameter int N = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic            i_a_s,
    input  logic [N-10:0]   i_a_sf,
    input  logic [N-5:0]    i_a_frac,
    input  logic            i_a_zero,
    input  logic            i_a_nar,
    input  logic            i_b_s,
    input  logic [N-10:0]   i_b_sf,
    input  logic [N-5:0]    i_b_frac,
    input  logic            i_b_zero,
    input  logic            i_b_nar,
    output logic            o_valid,
    input  logic            o_ready,
    output logic            o_s,
    output logic [N-10:0]   o_sf,
    output logic [N-5:0]    o_mant,
    output logic            o_guard,
    output logic            o_sticky,
    output logic            o_nzn
);

    localparam int SF     = N - 9;
    localparam int F      = N - 4;
    localparam int W      = 2 * F + 1;
    localparam int AW     = 2 * F + 2;
    localparam int SFW    = SF + 2;
    localparam int CW     = $clog2(F + 1);
    localparam int SF_MAX = (2 ** (SF - 2)) - 1;
    localparam int SF_MIN = -(2 ** (SF - 2));

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_NORM = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [AW-1:0]         mcand_q, mcand_d;
    logic [F:0]            mplier_q, mplier_d;
    logic                  s_q, s_d;
    logic signed [SFW-1:0] sf_sum_q, sf_sum_d;
    logic                  nar_q, nar_d;
    logic                  zero_q, zero_d;

    logic                  o_valid_q, o_valid_d;
    logic                  o_s_q, o_s_d;
    logic [SF-1:0]         o_sf_q, o_sf_d;
    logic [F-1:0]          o_mant_q, o_mant_d;
    logic                  o_guard_q, o_guard_d;
    logic                  o_sticky_q, o_sticky_d;
    logic                  o_nzn_q, o_nzn_d;

    logic [W-1:0]          frac_s;
    logic signed [SFW-1:0] sf_s;

    // Normalise the finished product, apply the sign convention and saturate.
    always_comb begin
        frac_s = {W{1'b0}};
        sf_s   = sf_sum_q;
        if (acc_q[AW-1]) begin
            frac_s = acc_q[W-1:0];
            sf_s   = sf_sum_q + SFW'(1);
        end else begin
            frac_s = {acc_q[W-2:0], 1'b0};
            sf_s   = sf_sum_q;
        end
        // Negative results: fraction is two's-complemented; an exact power of two borrows from sf.
        if (s_q) begin
            if (|frac_s) begin
                frac_s = (~frac_s) + W'(1);
            end else begin
                sf_s = sf_s - SFW'(1);
            end
        end else begin
            frac_s = frac_s;
        end
    end

    // Next-state, datapath and output-register computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        s_d        = s_q;
        sf_sum_d   = sf_sum_q;
        nar_d      = nar_q;
        zero_d     = zero_q;
        o_valid_d  = o_valid_q;
        o_s_d      = o_s_q;
        o_sf_d     = o_sf_q;
        o_mant_d   = o_mant_q;
        o_guard_d  = o_guard_q;
        o_sticky_d = o_sticky_q;
        o_nzn_d    = o_nzn_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    s_d      = i_a_s ^ i_b_s;
                    sf_sum_d = $signed({{2{i_a_sf[SF-1]}}, i_a_sf})
                             + $signed({{2{i_b_sf[SF-1]}}, i_b_sf});
                    nar_d    = i_a_nar | i_b_nar;
                    zero_d   = i_a_zero | i_b_zero;
                    cnt_d    = {CW{1'b0}};
                    acc_d    = {AW{1'b0}};
                    mcand_d  = {{(AW-F-1){1'b0}}, 1'b1, i_a_frac};
                    mplier_d = {1'b1, i_b_frac};
                    // Specials skip the multiply and are resolved in the normalise step.
                    if (i_a_nar | i_b_nar | i_a_zero | i_b_zero) begin
                        state_d = ST_NORM;
                    end else begin
                        state_d = ST_MUL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = {mcand_q[AW-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[F:1]};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(F)) begin
                    state_d = ST_NORM;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_NORM: begin
                o_valid_d = 1'b1;
                state_d   = ST_DONE;
                if (nar_q) begin
                    o_s_d      = 1'b1;
                    o_sf_d     = {SF{1'b0}};
                    o_mant_d   = {F{1'b0}};
                    o_guard_d  = 1'b0;
                    o_sticky_d = 1'b0;
                    o_nzn_d    = 1'b0;
                end else if (zero_q) begin
                    o_s_d      = 1'b0;
                    o_sf_d     = {SF{1'b0}};
                    o_mant_d   = {F{1'b0}};
                    o_guard_d  = 1'b0;
                    o_sticky_d = 1'b0;
                    o_nzn_d    = 1'b0;
                end else begin
                    o_s_d   = s_q;
                    o_nzn_d = 1'b1;
                    if (sf_s > SFW'(SF_MAX)) begin
                        o_sf_d     = SF'(SF_MAX);
                        o_mant_d   = {F{1'b0}};
                        o_guard_d  = 1'b0;
                        o_sticky_d = 1'b1;
                    end else if (sf_s < $signed(SFW'(SF_MIN))) begin
                        o_sf_d     = SF'(SF_MIN);
                        o_mant_d   = {F{1'b0}};
                        o_guard_d  = 1'b0;
                        o_sticky_d = 1'b1;
                    end else begin
                        o_sf_d     = sf_s[SF-1:0];
                        o_mant_d   = frac_s[W-1:W-F];
                        o_guard_d  = frac_s[W-F-1];
                        o_sticky_d = |frac_s[W-F-2:0];
                    end
                end
            end
            ST_DONE: begin
                if (o_ready) begin
                    o_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                o_valid_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CW{1'b0}};
            acc_q      <= {AW{1'b0}};
            mcand_q    <= {AW{1'b0}};
            mplier_q   <= {(F+1){1'b0}};
            s_q        <= 1'b0;
            sf_sum_q   <= {SFW{1'b0}};
            nar_q      <= 1'b0;
            zero_q     <= 1'b0;
            o_valid_q  <= 1'b0;
            o_s_q      <= 1'b0;
            o_sf_q     <= {SF{1'b0}};
            o_mant_q   <= {F{1'b0}};
            o_guard_q  <= 1'b0;
            o_sticky_q <= 1'b0;
            o_nzn_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            s_q        <= s_d;
            sf_sum_q   <= sf_sum_d;
            nar_q      <= nar_d;
            zero_q     <= zero_d;
            o_valid_q  <= o_valid_d;
            o_s_q      <= o_s_d;
            o_sf_q     <= o_sf_d;
            o_mant_q   <= o_mant_d;
            o_guard_q  <= o_guard_d;
            o_sticky_q <= o_sticky_d;
            o_nzn_q    <= o_nzn_d;
        end
    end

    assign i_ready  = (state_q == ST_IDLE);
    assign o_valid  = o_valid_q;
    assign o_s      = o_s_q;
    assign o_sf     = o_sf_q;
    assign o_mant   = o_mant_q;
    assign o_guard  = o_guard_q;
    assign o_sticky = o_sticky_q;
    assign o_nzn    = o_nzn_q;

endmodule

// File: tb/tb_posit_mul_core_seq.sv
// Directed bench for posit_mul_core_seq: hand-computed products, specials, saturation, stall and reset.
module tb_posit_mul_core_seq;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        i_ready;
    logic        i_a_s, i_a_zero, i_a_nar;
    logic [6:0]  i_a_sf;
    logic [11:0] i_a_frac;
    logic        i_b_s, i_b_zero, i_b_nar;
    logic [6:0]  i_b_sf;
    logic [11:0] i_b_frac;
    logic        o_valid;
    logic        o_ready;
    logic        o_s;
    logic [6:0]  o_sf;
    logic [11:0] o_mant;
    logic        o_guard, o_sticky, o_nzn;

    int passed = 0;
    int total  = 0;

    posit_mul_core_seq #(.N(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_a_s    (i_a_s),
        .i_a_sf   (i_a_sf),
        .i_a_frac (i_a_frac),
        .i_a_zero (i_a_zero),
        .i_a_nar  (i_a_nar),
        .i_b_s    (i_b_s),
        .i_b_sf   (i_b_sf),
        .i_b_frac (i_b_frac),
        .i_b_zero (i_b_zero),
        .i_b_nar  (i_b_nar),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_s      (o_s),
        .o_sf     (o_sf),
        .o_mant   (o_mant),
        .o_guard  (o_guard),
        .o_sticky (o_sticky),
        .o_nzn    (o_nzn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an operand pair, accept it, and measure edges until o_valid.
    task automatic start_op(input logic sa, input logic [6:0] sfa, input logic [11:0] fa,
                            input logic za, input logic na,
                            input logic sb, input logic [6:0] sfb, input logic [11:0] fb,
                            input logic zb, input logic nb);
        @(negedge clk);
        i_a_s = sa; i_a_sf = sfa; i_a_frac = fa; i_a_zero = za; i_a_nar = na;
        i_b_s = sb; i_b_sf = sfb; i_b_frac = fb; i_b_zero = zb; i_b_nar = nb;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid  = 1'b0;
        i_a_frac = 12'h5A5; i_b_frac = 12'hA5A; i_a_sf = 7'h33; i_b_sf = 7'h4C;
        i_a_s = 1'b1; i_b_s = 1'b0; i_a_zero = 1'b0; i_b_zero = 1'b0; i_a_nar = 1'b0; i_b_nar = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!o_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic chk_res(input string tag, input logic s, input logic [6:0] sf, input logic [11:0] mant,
                           input logic g, input logic st, input logic nzn);
        chk({tag, "_s"},      {31'd0, o_s},      {31'd0, s});
        chk({tag, "_sf"},     {25'd0, o_sf},     {25'd0, sf});
        chk({tag, "_mant"},   {20'd0, o_mant},   {20'd0, mant});
        chk({tag, "_guard"},  {31'd0, o_guard},  {31'd0, g});
        chk({tag, "_sticky"}, {31'd0, o_sticky}, {31'd0, st});
        chk({tag, "_nzn"},    {31'd0, o_nzn},    {31'd0, nzn});
    endtask

    task automatic release_res(input string tag);
        @(negedge clk);
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        o_ready = 1'b0;
        chk({tag, "_vld_clr"}, {31'd0, o_valid}, 32'd0);
        chk({tag, "_rdy_set"}, {31'd0, i_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
        i_a_s = 1'b0; i_a_sf = 7'd0; i_a_frac = 12'd0; i_a_zero = 1'b0; i_a_nar = 1'b0;
        i_b_s = 1'b0; i_b_sf = 7'd0; i_b_frac = 12'd0; i_b_zero = 1'b0; i_b_nar = 1'b0;
        #23;
        chk("rst_ready", {31'd0, i_ready}, 32'd1);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk_res("rst", 1'b0, 7'd0, 12'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.0 x 1.0
        start_op(1'b0, 7'd0, 12'h000, 1'b0, 1'b0, 1'b0, 7'd0, 12'h000, 1'b0, 1'b0);
        wait_result("one", 14);
        chk_res("one", 1'b0, 7'd0, 12'h000, 1'b0, 1'b0, 1'b1);
        release_res("one");

        // 1.5 x 1.5 with a 5-cycle downstream stall
        start_op(1'b0, 7'd0, 12'h800, 1'b0, 1'b0, 1'b0, 7'd0, 12'h800, 1'b0, 1'b0);
        wait_result("p15", 14);
        chk_res("p15", 1'b0, 7'd1, 12'h200, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", {31'd0, o_valid}, 32'd1);
            chk("stall_ready", {31'd0, i_ready}, 32'd0);
            chk("stall_mant",  {20'd0, o_mant},  32'h200);
            chk("stall_sf",    {25'd0, o_sf},    32'd1);
        end
        release_res("p15");

        // 0xFFF x 0xFFF: guard 0, sticky 1
        start_op(1'b0, 7'd0, 12'hFFF, 1'b0, 1'b0, 1'b0, 7'd0, 12'hFFF, 1'b0, 1'b0);
        wait_result("pfff", 14);
        chk_res("pfff", 1'b0, 7'd1, 12'hFFE, 1'b0, 1'b1, 1'b1);
        release_res("pfff");

        // -1.5 x 1.0
        start_op(1'b1, 7'd0, 12'h800, 1'b0, 1'b0, 1'b0, 7'd0, 12'h000, 1'b0, 1'b0);
        wait_result("n15", 14);
        chk_res("n15", 1'b1, 7'd0, 12'h800, 1'b0, 1'b0, 1'b1);
        release_res("n15");

        // -1.0 x 1.0: exact power of two borrows from sf
        start_op(1'b1, 7'd0, 12'h000, 1'b0, 1'b0, 1'b0, 7'd0, 12'h000, 1'b0, 1'b0);
        wait_result("n1", 14);
        chk_res("n1", 1'b1, 7'h7F, 12'h000, 1'b0, 1'b0, 1'b1);
        release_res("n1");

        // zero x NaR: NaR wins
        start_op(1'b0, 7'd0, 12'h000, 1'b1, 1'b0, 1'b0, 7'd0, 12'h000, 1'b0, 1'b1);
        wait_result("znar", 1);
        chk_res("znar", 1'b1, 7'd0, 12'h000, 1'b0, 1'b0, 1'b0);
        release_res("znar");

        // zero x (sf=3)
        start_op(1'b1, 7'd0, 12'h000, 1'b1, 1'b0, 1'b0, 7'd3, 12'h123, 1'b0, 1'b0);
        wait_result("zero", 1);
        chk_res("zero", 1'b0, 7'd0, 12'h000, 1'b0, 1'b0, 1'b0);
        release_res("zero");

        // Positive saturation: 29 + 29 = 58
        start_op(1'b0, 7'd29, 12'h000, 1'b0, 1'b0, 1'b0, 7'd29, 12'h000, 1'b0, 1'b0);
        wait_result("satp", 14);
        chk_res("satp", 1'b0, 7'd31, 12'h000, 1'b0, 1'b1, 1'b1);
        release_res("satp");

        // Negative saturation: -30 + -30 = -60
        start_op(1'b0, 7'h62, 12'h000, 1'b0, 1'b0, 1'b0, 7'h62, 12'h000, 1'b0, 1'b0);
        wait_result("satn", 14);
        chk_res("satn", 1'b0, 7'h60, 12'h000, 1'b0, 1'b1, 1'b1);
        release_res("satn");

        // Abort at MUL iteration 6
        start_op(1'b0, 7'd0, 12'hFFF, 1'b0, 1'b0, 1'b0, 7'd0, 12'hFFF, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, o_valid}, 32'd0);
        chk("abort_ready", {31'd0, i_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.5 x 1.0 after abort
        start_op(1'b0, 7'd0, 12'h800, 1'b0, 1'b0, 1'b0, 7'd0, 12'h000, 1'b0, 1'b0);
        wait_result("post", 14);
        chk_res("post", 1'b0, 7'd0, 12'h800, 1'b0, 1'b0, 1'b1);
        release_res("post");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
